// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_pkg
// Description : Shared types and helpers for the scanning N:1 multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

    // Largest channel count the multiplexer is intended to support
    localparam int MUX_MAX_CH = 64;

    // Operating mode of the multiplexer
    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_t;

    // Index width for n items, never narrower than one bit
    function automatic int sel_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_next_ch.sv
`default_nettype none
// ============================================================================
// Module      : mux_next_ch
// Description : Combinational search for the next enabled channel above a
//               given index (wrapping to the lowest enabled channel), plus the
//               lowest enabled index and an any-enabled flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_next_ch
    import mux_scan_pkg::*;
#(
    parameter  int NUM_CH = 8,
    localparam int SEL_W  = sel_w(NUM_CH)
) (
    input  logic [SEL_W-1:0]  i_cur,
    input  logic [NUM_CH-1:0] i_en_mask,
    output logic [SEL_W-1:0]  o_next_idx,
    output logic              o_wrapped,
    output logic              o_any_en,
    output logic [SEL_W-1:0]  o_low_idx
);

    logic [SEL_W-1:0] w_up_idx;
    logic             w_up_found;

    // Descending walk so the lowest qualifying channel is the last one written
    always_comb begin
        w_up_idx   = '0;
        w_up_found = 1'b0;
        o_low_idx  = '0;
        o_any_en   = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_en_mask[i]) begin
                o_low_idx = SEL_W'(i);
                o_any_en  = 1'b1;
                if (SEL_W'(i) > i_cur) begin
                    w_up_idx   = SEL_W'(i);
                    w_up_found = 1'b1;
                end
            end
        end
        // With a single enabled channel this wraps onto itself, as intended
        o_wrapped  = o_any_en && !w_up_found;
        o_next_idx = w_up_found ? w_up_idx : o_low_idx;
    end

endmodule
`default_nettype wire

// File: rtl/mux_scan_n.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_n
// Description : Registered N:1 multiplexer with a MANUAL mode (channel taken
//               from sel) and a SCAN mode (channels visited in turn, each held
//               for DWELL cycles, wrap pulse on return to the lowest channel).
//               Optional macro MUX_CH_MASK_EN adds the ch_mask port.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_n
    import mux_scan_pkg::*;
#(
    parameter  int NUM_CH = 8,
    parameter  int WIDTH  = 8,
    parameter  int DWELL  = 4,
    localparam int SEL_W  = sel_w(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    auto_en,
`ifdef MUX_CH_MASK_EN
    input  logic [NUM_CH-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    output logic                    wrap
);

    localparam int              c_dw_w       = sel_w(DWELL);
    localparam logic [c_dw_w-1:0] c_dwell_last = c_dw_w'(DWELL - 1);

    mode_t              r_state;
    mode_t              w_state_nxt;
    logic [c_dw_w-1:0]  r_dwell;
    logic [c_dw_w-1:0]  w_dwell_nxt;
    logic [WIDTH-1:0]   r_out_data;
    logic [SEL_W-1:0]   r_out_sel;
    logic               r_out_valid;
    logic               r_wrap;

    logic [NUM_CH-1:0]  w_en_mask;
    logic [SEL_W-1:0]   w_next_sel;
    logic               w_load;
    logic               w_valid_nxt;
    logic               w_wrap_nxt;
    logic               w_sel_ok;
    logic               w_cur_en;
    logic [WIDTH-1:0]   w_sel_data;
    logic [SEL_W-1:0]   w_adv_idx;
    logic               w_adv_wrapped;
    logic               w_any_en;
    logic [SEL_W-1:0]   w_low_idx;

`ifdef MUX_CH_MASK_EN
    assign w_en_mask = ch_mask;
`else
    assign w_en_mask = '1;
`endif

    mux_next_ch #(
        .NUM_CH (NUM_CH)
    ) u_next_ch (
        .i_cur      (r_out_sel),
        .i_en_mask  (w_en_mask),
        .o_next_idx (w_adv_idx),
        .o_wrapped  (w_adv_wrapped),
        .o_any_en   (w_any_en),
        .o_low_idx  (w_low_idx)
    );

    // Legality of the manual request and of the channel currently shown
    always_comb begin
        w_sel_ok = 1'b0;
        w_cur_en = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i) && w_en_mask[i]) begin
                w_sel_ok = 1'b1;
            end
            if (r_out_sel == SEL_W'(i) && w_en_mask[i]) begin
                w_cur_en = 1'b1;
            end
        end
    end

    // Mode register: follows auto_en one cycle late
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MODE_MANUAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next mode, next channel, dwell progress and wrap decision
    always_comb begin
        w_state_nxt = auto_en ? MODE_SCAN : MODE_MANUAL;
        w_next_sel  = r_out_sel;
        w_load      = 1'b0;
        w_valid_nxt = r_out_valid;
        w_dwell_nxt = '0;
        w_wrap_nxt  = 1'b0;
        case (r_state)
            MODE_MANUAL: begin
                if (!auto_en) begin
                    if (w_sel_ok) begin
                        w_next_sel  = sel;
                        w_load      = 1'b1;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_valid_nxt = 1'b0;
                    end
                end else if (!w_any_en) begin
                    w_valid_nxt = 1'b0;
                end else begin
                    // Scan entry: keep the shown channel if it is still usable
                    w_next_sel  = (r_out_valid && w_cur_en) ? r_out_sel : w_low_idx;
                    w_load      = 1'b1;
                    w_valid_nxt = 1'b1;
                end
            end
            MODE_SCAN: begin
                if (!w_any_en) begin
                    w_valid_nxt = 1'b0;
                end else if (!r_out_valid) begin
                    w_next_sel  = w_low_idx;
                    w_load      = 1'b1;
                    w_valid_nxt = 1'b1;
                end else if (r_dwell == c_dwell_last) begin
                    w_next_sel  = w_adv_idx;
                    w_wrap_nxt  = w_adv_wrapped;
                    w_load      = 1'b1;
                    w_valid_nxt = 1'b1;
                end else begin
                    // Holding the channel but still re-sampling its data
                    w_dwell_nxt = r_dwell + c_dw_w'(1);
                    w_load      = 1'b1;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // Data of the channel about to be shown
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_next_sel == SEL_W'(i)) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output and dwell registers; data and index always load together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_wrap      <= 1'b0;
            r_dwell     <= '0;
        end else begin
            if (w_load) begin
                r_out_data <= w_sel_data;
                r_out_sel  <= w_next_sel;
            end
            r_out_valid <= w_valid_nxt;
            r_wrap      <= w_wrap_nxt;
            r_dwell     <= w_dwell_nxt;
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;
    assign wrap      = r_wrap;

endmodule
`default_nettype wire
